// File: rtl/i2c_reg_pkg.sv
// Shared constants for the I2C controller APB register file:
// register indices, command-enable bit position and APB FSM encoding.
package i2c_reg_pkg;

    localparam int unsigned IDX_PRESCALER  = 0;
    localparam int unsigned IDX_CMD        = 1;
    localparam int unsigned IDX_TRANSMIT   = 2;
    localparam int unsigned IDX_RECEIVE    = 3;
    localparam int unsigned IDX_ADDRESS_RW = 4;
    localparam int unsigned IDX_STATUS     = 5;
    localparam int unsigned IDX_IRQ_EN     = 6;
    localparam int unsigned IDX_IRQ_STAT   = 7;
    localparam int unsigned IDX_LAST       = 7;

    localparam int unsigned CMD_EN_BIT = 6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } apb_state_e;

endpackage

// File: rtl/i2c_irq_ctrl.sv
// Interrupt enable / sticky status registers and the registered request line.
// A new event always wins over a simultaneous write-one-to-clear.
module i2c_irq_ctrl #(
    parameter int NUM_IRQ = 4
) (
    input  logic               pclk_i,
    input  logic               preset_i,
    input  logic [NUM_IRQ-1:0] events,
    input  logic               en_we,
    input  logic [NUM_IRQ-1:0] en_wdata,
    input  logic               clr_we,
    input  logic [NUM_IRQ-1:0] clr_mask,
    output logic [NUM_IRQ-1:0] irq_en,
    output logic [NUM_IRQ-1:0] irq_stat,
    output logic               irq
);

    logic [NUM_IRQ-1:0] clr_bits;

    assign clr_bits = clr_we ? clr_mask : '0;

    always_ff @(posedge pclk_i or posedge preset_i) begin
        if (preset_i) begin
            irq_en   <= '0;
            irq_stat <= '0;
            irq      <= 1'b0;
        end else begin
            if (en_we) begin
                irq_en <= en_wdata;
            end
            irq_stat <= (irq_stat & ~clr_bits) | events;
            irq      <= |(irq_stat & irq_en);
        end
    end

endmodule

// File: rtl/i2c_apb_regfile.sv
// APB slave register file for the I2C master core, with configurable wait
// states, FIFO push/pop strobes and stop-condition handling of the enable bit.
//
// state     | meaning
// ST_IDLE   | no transfer; waiting for a setup phase
// ST_ACCESS | access phase, counting wait cycles before pready_o
// ST_RESP   | pready_o high with sampled data/error; commits on psel&penable
module i2c_apb_regfile
    import i2c_reg_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 0,
    parameter int NUM_IRQ     = 4,
    parameter int PRESC_RST   = 4,
    parameter int CMD_RST     = 4
) (
    input  logic               pclk_i,
    input  logic               preset_i,
    input  logic               psel_i,
    input  logic               penable_i,
    input  logic               pwrite_i,
    input  logic [ADDR_W-1:0]  paddr_i,
    input  logic [DATA_W-1:0]  pwdata_i,
    output logic [DATA_W-1:0]  prdata_o,
    output logic               pready_o,
    output logic               pslverr_o,
    input  logic               stop_cnt_i,
    input  logic [DATA_W-1:0]  status_i,
    input  logic [DATA_W-1:0]  receive_i,
    input  logic               rx_empty_i,
    input  logic               tx_full_i,
    input  logic [NUM_IRQ-1:0] event_i,
    output logic [DATA_W-1:0]  prescaler_o,
    output logic [DATA_W-1:0]  cmd_o,
    output logic [DATA_W-1:0]  address_rw_o,
    output logic [DATA_W-1:0]  transmit_o,
    output logic               tx_push_o,
    output logic               rx_pop_o,
    output logic               irq_o
);

    localparam logic [1:0] WS_LAST = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

    apb_state_e         state;
    logic [1:0]         cnt;

    logic               hit_presc, hit_cmd, hit_tx, hit_rx, hit_addr;
    logic               hit_status, hit_irq_en, hit_irq_stat, addr_bad;
    logic               acc_err, commit, wr_ok, rd_ok;
    logic [DATA_W-1:0]  rd_data, sample_rdata, cmd_next;
    logic [NUM_IRQ-1:0] irq_en, irq_stat;

    assign hit_presc    = (paddr_i == ADDR_W'(IDX_PRESCALER));
    assign hit_cmd      = (paddr_i == ADDR_W'(IDX_CMD));
    assign hit_tx       = (paddr_i == ADDR_W'(IDX_TRANSMIT));
    assign hit_rx       = (paddr_i == ADDR_W'(IDX_RECEIVE));
    assign hit_addr     = (paddr_i == ADDR_W'(IDX_ADDRESS_RW));
    assign hit_status   = (paddr_i == ADDR_W'(IDX_STATUS));
    assign hit_irq_en   = (paddr_i == ADDR_W'(IDX_IRQ_EN));
    assign hit_irq_stat = (paddr_i == ADDR_W'(IDX_IRQ_STAT));
    assign addr_bad     = (paddr_i > ADDR_W'(IDX_LAST));

    assign acc_err = addr_bad
                   | (pwrite_i  & (hit_rx | hit_status))
                   | (pwrite_i  & hit_tx & tx_full_i)
                   | (!pwrite_i & hit_rx & rx_empty_i);

    // The error flag latched with pready_o gates the commit, so the decision
    // is taken from the inputs seen when the response was produced.
    assign commit = (state == ST_RESP) & psel_i & penable_i;
    assign wr_ok  = commit & pwrite_i & !pslverr_o;
    assign rd_ok  = commit & !pwrite_i & !pslverr_o;

    always_comb begin
        rd_data = '0;
        if (hit_presc)    rd_data = prescaler_o;
        if (hit_cmd)      rd_data = cmd_o;
        if (hit_tx)       rd_data = transmit_o;
        if (hit_rx)       rd_data = receive_i;
        if (hit_addr)     rd_data = address_rw_o;
        if (hit_status)   rd_data = status_i;
        if (hit_irq_en)   rd_data[NUM_IRQ-1:0] = irq_en;
        if (hit_irq_stat) rd_data[NUM_IRQ-1:0] = irq_stat;
    end

    assign sample_rdata = (pwrite_i || acc_err) ? '0 : rd_data;

    always_comb begin
        cmd_next = cmd_o;
        if (wr_ok && hit_cmd) begin
            cmd_next = pwdata_i;
        end
        if (stop_cnt_i) begin
            cmd_next[CMD_EN_BIT] = 1'b0;
        end
    end

    always_ff @(posedge pclk_i or posedge preset_i) begin
        if (preset_i) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            pready_o     <= 1'b0;
            pslverr_o    <= 1'b0;
            prdata_o     <= '0;
            prescaler_o  <= DATA_W'(PRESC_RST);
            cmd_o        <= DATA_W'(CMD_RST);
            address_rw_o <= '0;
            transmit_o   <= '0;
            tx_push_o    <= 1'b0;
            rx_pop_o     <= 1'b0;
        end else begin
            tx_push_o <= 1'b0;
            rx_pop_o  <= 1'b0;
            cmd_o     <= cmd_next;

            case (state)
                ST_IDLE: begin
                    if (psel_i && !penable_i) begin
                        cnt <= '0;
                        if (WAIT_STATES == 0) begin
                            state     <= ST_RESP;
                            pready_o  <= 1'b1;
                            pslverr_o <= acc_err;
                            prdata_o  <= sample_rdata;
                        end else begin
                            state <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (!psel_i) begin
                        state <= ST_IDLE;
                    end else if (cnt == WS_LAST) begin
                        state     <= ST_RESP;
                        pready_o  <= 1'b1;
                        pslverr_o <= acc_err;
                        prdata_o  <= sample_rdata;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                ST_RESP: begin
                    if (!psel_i || penable_i) begin
                        state     <= ST_IDLE;
                        pready_o  <= 1'b0;
                        pslverr_o <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            if (wr_ok && hit_presc) prescaler_o  <= pwdata_i;
            if (wr_ok && hit_addr)  address_rw_o <= pwdata_i;
            if (wr_ok && hit_tx) begin
                transmit_o <= pwdata_i;
                tx_push_o  <= 1'b1;
            end
            if (rd_ok && hit_rx) begin
                rx_pop_o <= 1'b1;
            end
        end
    end

    i2c_irq_ctrl #(
        .NUM_IRQ (NUM_IRQ)
    ) u_irq (
        .pclk_i   (pclk_i),
        .preset_i (preset_i),
        .events   (event_i),
        .en_we    (wr_ok & hit_irq_en),
        .en_wdata (pwdata_i[NUM_IRQ-1:0]),
        .clr_we   (wr_ok & hit_irq_stat),
        .clr_mask (pwdata_i[NUM_IRQ-1:0]),
        .irq_en   (irq_en),
        .irq_stat (irq_stat),
        .irq      (irq_o)
    );

endmodule

// File: tb/tb_i2c_apb_regfile.sv
// Directed bench for the I2C APB register file built with two wait states.
module tb_i2c_apb_regfile;

    logic       pclk_i = 1'b0;
    logic       preset_i;
    logic       psel_i, penable_i, pwrite_i;
    logic [7:0] paddr_i, pwdata_i, prdata_o;
    logic       pready_o, pslverr_o;
    logic       stop_cnt_i, rx_empty_i, tx_full_i;
    logic [7:0] status_i, receive_i;
    logic [3:0] event_i;
    logic [7:0] prescaler_o, cmd_o, address_rw_o, transmit_o;
    logic       tx_push_o, rx_pop_o, irq_o;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] rd;
    logic       er;
    int         acc;

    always #5 pclk_i = ~pclk_i;

    i2c_apb_regfile #(
        .DATA_W(8), .ADDR_W(8), .WAIT_STATES(2), .NUM_IRQ(4), .PRESC_RST(4), .CMD_RST(4)
    ) dut (
        .pclk_i(pclk_i), .preset_i(preset_i), .psel_i(psel_i), .penable_i(penable_i),
        .pwrite_i(pwrite_i), .paddr_i(paddr_i), .pwdata_i(pwdata_i), .prdata_o(prdata_o),
        .pready_o(pready_o), .pslverr_o(pslverr_o), .stop_cnt_i(stop_cnt_i),
        .status_i(status_i), .receive_i(receive_i), .rx_empty_i(rx_empty_i),
        .tx_full_i(tx_full_i), .event_i(event_i), .prescaler_o(prescaler_o),
        .cmd_o(cmd_o), .address_rw_o(address_rw_o), .transmit_o(transmit_o),
        .tx_push_o(tx_push_o), .rx_pop_o(rx_pop_o), .irq_o(irq_o)
    );

    // Full APB transfer; returns at commit edge + 1 so next-cycle strobes are visible.
    task automatic apb(input logic wr, input logic [7:0] a, input logic [7:0] d,
                       input logic [3:0] evt, output logic [7:0] rdat,
                       output logic err, output int cycles);
        @(posedge pclk_i); #1;
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = wr; paddr_i = a; pwdata_i = d;
        @(posedge pclk_i); #1;
        penable_i = 1'b1;
        cycles = 1;
        while (!pready_o && cycles < 20) begin
            @(posedge pclk_i); #1;
            cycles++;
        end
        rdat = prdata_o;
        err  = pslverr_o;
        event_i = evt;
        @(posedge pclk_i); #1;
        event_i = 4'h0;
        psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++; if (prescaler_o !== 8'h04) begin n_bad++; $display("FAIL rst_presc got %h want 04", prescaler_o); end
        n_cmp++; if (cmd_o !== 8'h04) begin n_bad++; $display("FAIL rst_cmd got %h want 04", cmd_o); end
        n_cmp++; if (address_rw_o !== 8'h00) begin n_bad++; $display("FAIL rst_addr got %h want 00", address_rw_o); end
        n_cmp++; if (transmit_o !== 8'h00) begin n_bad++; $display("FAIL rst_tx got %h want 00", transmit_o); end
        n_cmp++; if ({pready_o, pslverr_o, tx_push_o, rx_pop_o, irq_o} !== 5'b0) begin
            n_bad++; $display("FAIL rst_flags got %b want 00000", {pready_o, pslverr_o, tx_push_o, rx_pop_o, irq_o}); end
        n_cmp++; if (prdata_o !== 8'h00) begin n_bad++; $display("FAIL rst_prdata got %h want 00", prdata_o); end
    endtask

    task automatic test_wait_states();
        apb(1'b1, 8'h00, 8'h5A, 4'h0, rd, er, acc);
        n_cmp++; if (acc !== 3) begin n_bad++; $display("FAIL ws_ready_cycle got %0d want 3", acc); end
        n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL ws_err got %b want 0", er); end
        n_cmp++; if (prescaler_o !== 8'h5A) begin n_bad++; $display("FAIL ws_presc got %h want 5a", prescaler_o); end
        apb(1'b0, 8'h00, 8'h00, 4'h0, rd, er, acc);
        n_cmp++; if (rd !== 8'h5A) begin n_bad++; $display("FAIL ws_readback got %h want 5a", rd); end
        n_cmp++; if (pready_o !== 1'b0) begin n_bad++; $display("FAIL ws_ready_clear got %b want 0", pready_o); end
    endtask

    task automatic test_transmit();
        tx_full_i = 1'b0;
        apb(1'b1, 8'h02, 8'h33, 4'h0, rd, er, acc);
        n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL tx_err got %b want 0", er); end
        n_cmp++; if (transmit_o !== 8'h33) begin n_bad++; $display("FAIL tx_data got %h want 33", transmit_o); end
        n_cmp++; if (tx_push_o !== 1'b1) begin n_bad++; $display("FAIL tx_push got %b want 1", tx_push_o); end
        @(posedge pclk_i); #1;
        n_cmp++; if (tx_push_o !== 1'b0) begin n_bad++; $display("FAIL tx_push_width got %b want 0", tx_push_o); end
        tx_full_i = 1'b1;
        apb(1'b1, 8'h02, 8'h77, 4'h0, rd, er, acc);
        n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL txfull_err got %b want 1", er); end
        n_cmp++; if (tx_push_o !== 1'b0) begin n_bad++; $display("FAIL txfull_push got %b want 0", tx_push_o); end
        n_cmp++; if (transmit_o !== 8'h33) begin n_bad++; $display("FAIL txfull_data got %h want 33", transmit_o); end
        tx_full_i = 1'b0;
    endtask

    task automatic test_receive();
        receive_i = 8'hA5; rx_empty_i = 1'b0;
        apb(1'b0, 8'h03, 8'h00, 4'h0, rd, er, acc);
        n_cmp++; if (rd !== 8'hA5) begin n_bad++; $display("FAIL rx_data got %h want a5", rd); end
        n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL rx_err got %b want 0", er); end
        n_cmp++; if (rx_pop_o !== 1'b1) begin n_bad++; $display("FAIL rx_pop got %b want 1", rx_pop_o); end
        @(posedge pclk_i); #1;
        n_cmp++; if (rx_pop_o !== 1'b0) begin n_bad++; $display("FAIL rx_pop_width got %b want 0", rx_pop_o); end
        rx_empty_i = 1'b1;
        apb(1'b0, 8'h03, 8'h00, 4'h0, rd, er, acc);
        n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL rxempty_err got %b want 1", er); end
        n_cmp++; if (rx_pop_o !== 1'b0) begin n_bad++; $display("FAIL rxempty_pop got %b want 0", rx_pop_o); end
        rx_empty_i = 1'b0;
    endtask

    task automatic test_errors();
        apb(1'b1, 8'h05, 8'h11, 4'h0, rd, er, acc);
        n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL wr_status_err got %b want 1", er); end
        apb(1'b1, 8'h03, 8'h11, 4'h0, rd, er, acc);
        n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL wr_receive_err got %b want 1", er); end
        apb(1'b1, 8'h08, 8'h99, 4'h0, rd, er, acc);
        n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL wr_oob_err got %b want 1", er); end
        n_cmp++; if (prescaler_o !== 8'h5A) begin n_bad++; $display("FAIL oob_side_effect got %h want 5a", prescaler_o); end
        apb(1'b0, 8'h09, 8'h00, 4'h0, rd, er, acc);
        n_cmp++; if ({er, rd} !== {1'b1, 8'h00}) begin n_bad++; $display("FAIL rd_oob got err=%b data=%h want err=1 data=00", er, rd); end
        status_i = 8'h3C;
        apb(1'b0, 8'h05, 8'h00, 4'h0, rd, er, acc);
        n_cmp++; if ({er, rd} !== {1'b0, 8'h3C}) begin n_bad++; $display("FAIL rd_status got err=%b data=%h want err=0 data=3c", er, rd); end
    endtask

    task automatic test_stop_cnt();
        stop_cnt_i = 1'b1;
        apb(1'b1, 8'h01, 8'h44, 4'h0, rd, er, acc);
        stop_cnt_i = 1'b0;
        n_cmp++; if (cmd_o !== 8'h04) begin n_bad++; $display("FAIL stop_cmd_write got %h want 04", cmd_o); end
        apb(1'b1, 8'h01, 8'h44, 4'h0, rd, er, acc);
        n_cmp++; if (cmd_o !== 8'h44) begin n_bad++; $display("FAIL cmd_write got %h want 44", cmd_o); end
        stop_cnt_i = 1'b1;
        @(posedge pclk_i); #1;
        stop_cnt_i = 1'b0;
        n_cmp++; if (cmd_o !== 8'h04) begin n_bad++; $display("FAIL stop_clear got %h want 04", cmd_o); end
    endtask

    task automatic test_irq();
        apb(1'b1, 8'h06, 8'h01, 4'h0, rd, er, acc);
        n_cmp++; if (irq_o !== 1'b0) begin n_bad++; $display("FAIL irq_idle got %b want 0", irq_o); end
        event_i = 4'b0001;
        @(posedge pclk_i); #1;
        event_i = 4'b0000;
        n_cmp++; if (irq_o !== 1'b0) begin n_bad++; $display("FAIL irq_latency got %b want 0", irq_o); end
        @(posedge pclk_i); #1;
        n_cmp++; if (irq_o !== 1'b1) begin n_bad++; $display("FAIL irq_set got %b want 1", irq_o); end
        apb(1'b1, 8'h07, 8'h01, 4'b0001, rd, er, acc);
        @(posedge pclk_i); #1;
        n_cmp++; if (irq_o !== 1'b1) begin n_bad++; $display("FAIL irq_set_wins got %b want 1", irq_o); end
        apb(1'b0, 8'h07, 8'h00, 4'h0, rd, er, acc);
        n_cmp++; if (rd !== 8'h01) begin n_bad++; $display("FAIL irq_stat_read got %h want 01", rd); end
        apb(1'b1, 8'h07, 8'h01, 4'h0, rd, er, acc);
        @(posedge pclk_i); #1;
        n_cmp++; if (irq_o !== 1'b0) begin n_bad++; $display("FAIL irq_w1c got %b want 0", irq_o); end
        event_i = 4'b0010;
        @(posedge pclk_i); #1;
        event_i = 4'b0000;
        @(posedge pclk_i); #1;
        n_cmp++; if (irq_o !== 1'b0) begin n_bad++; $display("FAIL irq_masked got %b want 0", irq_o); end
        apb(1'b0, 8'h07, 8'h00, 4'h0, rd, er, acc);
        n_cmp++; if (rd !== 8'h02) begin n_bad++; $display("FAIL irq_stat_masked got %h want 02", rd); end
        apb(1'b0, 8'h06, 8'h00, 4'h0, rd, er, acc);
        n_cmp++; if (rd !== 8'h01) begin n_bad++; $display("FAIL irq_en_read got %h want 01", rd); end
    endtask

    task automatic test_abort();
        int seen;
        apb(1'b1, 8'h04, 8'h12, 4'h0, rd, er, acc);
        n_cmp++; if (address_rw_o !== 8'h12) begin n_bad++; $display("FAIL addr_write got %h want 12", address_rw_o); end
        @(posedge pclk_i); #1;
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1; paddr_i = 8'h04; pwdata_i = 8'h99;
        @(posedge pclk_i); #1;
        penable_i = 1'b1;
        @(posedge pclk_i); #1;
        psel_i = 1'b0; penable_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge pclk_i); #1;
            if (pready_o) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL abort_ready got %0d cycles want 0", seen); end
        n_cmp++; if (address_rw_o !== 8'h12) begin n_bad++; $display("FAIL abort_side_effect got %h want 12", address_rw_o); end
    endtask

    task automatic test_reset_in_flight();
        int seen;
        @(posedge pclk_i); #1;
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1; paddr_i = 8'h04; pwdata_i = 8'hFF;
        @(posedge pclk_i); #1;
        penable_i = 1'b1;
        #2 preset_i = 1'b1;
        #1;
        n_cmp++; if (address_rw_o !== 8'h00) begin n_bad++; $display("FAIL rstif_addr got %h want 00", address_rw_o); end
        n_cmp++; if (prescaler_o !== 8'h04) begin n_bad++; $display("FAIL rstif_presc got %h want 04", prescaler_o); end
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge pclk_i); #1;
            if (pready_o) seen++;
        end
        preset_i = 1'b0;
        psel_i = 1'b0; penable_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge pclk_i); #1;
            if (pready_o) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL rstif_ready got %0d cycles want 0", seen); end
        n_cmp++; if (address_rw_o !== 8'h00) begin n_bad++; $display("FAIL rstif_no_commit got %h want 00", address_rw_o); end
    endtask

    initial begin
        preset_i = 1'b1;
        psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = 8'h00; pwdata_i = 8'h00;
        stop_cnt_i = 1'b0; status_i = 8'h00; receive_i = 8'h00;
        rx_empty_i = 1'b0; tx_full_i = 1'b0; event_i = 4'h0;
        repeat (3) @(posedge pclk_i);
        #1 preset_i = 1'b0;
        test_reset();
        test_wait_states();
        test_transmit();
        test_receive();
        test_errors();
        test_stop_cnt();
        test_irq();
        test_abort();
        test_reset_in_flight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/i2c_apb_regfile.md
I2C_APB_REGFILE -- requirements
Module: i2c_apb_regfile

Interface
REQ-001 Parameters SHALL be, one per line:
- DATA_W, 8, register/APB data width (8..32).
- ADDR_W, 8, paddr_i width; register index = paddr_i.
- WAIT_STATES, 0, access-phase wait cycles before pready_o (0..3).
- NUM_IRQ, 4, interrupt sources (1..DATA_W).
- PRESC_RST, 4, prescaler reset value.
- CMD_RST, 4, cmd reset value.
REQ-002 Ports SHALL be:
- pclk_i  in  1  single clock.
- preset_i  in  1  reset, asynchronous, active-high.
- psel_i  in  1  APB select.
- penable_i  in  1  APB enable.
- pwrite_i  in  1  1=write.
- paddr_i  in  ADDR_W  register index.
- pwdata_i  in  DATA_W  write data.
- prdata_o  out  DATA_W  read data.
- pready_o  out  1  transfer complete.
- pslverr_o  out  1  transfer error.
- stop_cnt_i  in  1  core stop condition.
- status_i  in  DATA_W  core status.
- receive_i  in  DATA_W  RX FIFO head.
- rx_empty_i  in  1  RX FIFO empty.
- tx_full_i  in  1  TX FIFO full.
- event_i  in  NUM_IRQ  single-cycle interrupt event pulses.
- prescaler_o, cmd_o, address_rw_o, transmit_o  out  DATA_W  register contents.
- tx_push_o  out  1  one-cycle TX FIFO write strobe.
- rx_pop_o  out  1  one-cycle RX FIFO read strobe.
- irq_o  out  1  interrupt request.

Function
REQ-003 Register map SHALL be: 0x00 PRESCALER RW, 0x01 CMD RW, 0x02 TRANSMIT RW (write pushes), 0x03 RECEIVE RO (read pops), 0x04 ADDRESS_RW RW, 0x05 STATUS RO, 0x06 IRQ_EN RW (bits NUM_IRQ-1:0), 0x07 IRQ_STAT W1C; unused bits read 0.
REQ-004 FSM states SHALL be IDLE, ACCESS, RESP: IDLE->ACCESS on psel_i&!penable_i; ACCESS counts cnt 0..WAIT_STATES then ->RESP, setting pready_o=1, pslverr_o and prdata_o at that edge; WAIT_STATES=0 sets pready_o at the setup-phase edge (zero-wait).
REQ-005 In RESP with psel_i&penable_i the transfer SHALL commit at that edge, pready_o/pslverr_o clear, FSM ->IDLE.
REQ-006 psel_i dropping before commit SHALL return FSM to IDLE with no side effects.
REQ-007 pslverr_o=1 SHALL flag: index >0x07; write to 0x03/0x05; write 0x02 while tx_full_i; read 0x03 while rx_empty_i; errored transfers change no state and raise no strobe.
REQ-008 Error/status/data SHALL be sampled at the edge setting pready_o.
REQ-009 tx_push_o/rx_pop_o SHALL pulse exactly one cycle, the cycle after a successful commit.
REQ-010 stop_cnt_i=1 SHALL clear cmd[6]; a CMD write committing the same edge SHALL be applied with bit 6 forced 0; APB transfers otherwise proceed normally.
REQ-011 IRQ_STAT bit i SHALL set on event_i[i], clear on W1C; set wins over simultaneous clear.
REQ-012 irq_o SHALL be registered |(IRQ_STAT & IRQ_EN), one cycle after either changes.

Reset
REQ-013 preset_i SHALL immediately set prescaler=PRESC_RST, cmd=CMD_RST, all other registers, prdata_o, pready_o, pslverr_o, strobes, irq_o =0, FSM=IDLE; in-flight transfer discarded without commit.

Structure
REQ-014 Package i2c_reg_pkg SHALL hold register index constants, CMD_EN_BIT=6, FSM state encoding.
REQ-015 Sub-module i2c_irq_ctrl SHALL hold IRQ_EN, IRQ_STAT, irq_o.

Verification
REQ-016 WAIT_STATES=2: write 0x5A to 0x00 -> pready_o high 3rd access cycle, prescaler_o=0x5A, pslverr_o=0.
REQ-017 Write 0x33 to 0x02, tx_full_i=0 -> transmit_o=0x33, tx_push_o one cycle; repeat with tx_full_i=1 -> pslverr_o=1, no push.
REQ-018 Read 0x03, receive_i=0xA5 -> prdata_o=0xA5, rx_pop_o one cycle; rx_empty_i=1 -> pslverr_o=1, no pop.
REQ-019 Write CMD=0x44 same edge as stop_cnt_i -> cmd_o=0x04.
REQ-020 IRQ_EN=0x1, event_i[0] -> irq_o=1; W1C 0x1 with simultaneous event_i[0] -> stays 1; W1C alone -> 0.
REQ-021 preset_i asserted during ACCESS of write 0xFF to 0x04 -> address_rw_o=0, no pready_o.
